// File: rtl/hazard_stall_ctrl.sv
// Hazard sequencer for the 5-stage core: load-use stalls, branch flushes and
// data-memory wait states, with saturating performance counters and a memory watchdog.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int WAIT_W      = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic [2:0]       RegWriteE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] LoadStallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] MemWaitCnt
);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERROR    = 2'd2;

    localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

    logic [1:0]        state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lw_haz, mem_haz;
    logic              lw_apply, br_apply, mem_stall, err_hold;
    logic [2:0]        cnt_inc;
    logic [2:0][CNT_W-1:0] cnt;

    // x0 is never a real dependency, so RdE==0 suppresses the stall outright.
    assign lw_haz  = (ResultSrcE == 2'b01) && (RegWriteE != 3'd0) && (RdE != 5'd0) &&
                     ((Rs1D == RdE) || (Rs2D == RdE));
    assign mem_haz = MemReqM && !MemReadyM;

    always_comb begin
        next_state = state;
        lw_apply   = 1'b0;
        br_apply   = 1'b0;
        mem_stall  = 1'b0;
        err_hold   = 1'b0;
        if (rst) begin
            next_state = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (mem_haz) begin
                        mem_stall  = 1'b1;
                        next_state = MEM_WAIT;
                    end else if (PCSrcE) begin
                        br_apply = 1'b1;
                    end else if (lw_haz) begin
                        lw_apply = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // Branch/load-use hazards wait until the pipe advances back in RUN.
                    if (MemReadyM) begin
                        next_state = RUN;
                    end else begin
                        mem_stall = 1'b1;
                        if (wait_cnt == TIMEOUT)
                            next_state = ERROR;
                    end
                end
                ERROR: begin
                    err_hold = 1'b1;
                end
                default: begin
                    next_state = RUN;
                end
            endcase
        end
    end

    assign StallF = lw_apply | mem_stall | err_hold;
    assign StallD = lw_apply | mem_stall | err_hold;
    assign StallE = mem_stall | err_hold;
    assign StallM = mem_stall | err_hold;
    assign FlushD = rst | br_apply;
    assign FlushE = rst | br_apply | lw_apply;
    assign FlushW = mem_stall | err_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            MemErr   <= 1'b0;
        end else begin
            state  <= next_state;
            MemErr <= MemErr | (next_state == ERROR);
            if (state == RUN && mem_stall)
                wait_cnt <= {{(WAIT_W-1){1'b0}}, 1'b1};
            else if (state == MEM_WAIT && mem_stall && next_state != ERROR)
                wait_cnt <= wait_cnt + 1'b1;
            else if (next_state == RUN)
                wait_cnt <= '0;
        end
    end

    assign cnt_inc = {mem_stall, br_apply, lw_apply};

    // Counters stop at all-ones rather than wrapping.
    for (genvar i = 0; i < 3; i++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst)
                cnt[i] <= '0;
            else if (cnt_inc[i] && !(&cnt[i]))
                cnt[i] <= cnt[i] + 1'b1;
        end
    end

    assign LoadStallCnt = cnt[0];
    assign FlushCnt     = cnt[1];
    assign MemWaitCnt   = cnt[2];

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scoreboard bench for hazard_stall_ctrl: expected control vectors are
// queued as each cycle's stimulus is driven and compared once outputs settle.
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 4;

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    localparam logic [6:0] V_NONE = 7'b0000000;
    localparam logic [6:0] V_LW   = 7'b1100010;
    localparam logic [6:0] V_BR   = 7'b0000110;
    localparam logic [6:0] V_MEM  = 7'b1111001;
    localparam logic [6:0] V_RST  = 7'b0000110;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [4:0]       Rs1D, Rs2D, RdE;
    logic [1:0]       ResultSrcE;
    logic [2:0]       RegWriteE;
    logic             PCSrcE, MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [CNT_W-1:0] LoadStallCnt, FlushCnt, MemWaitCnt;

    int n_vec = 0;
    int n_err = 0;
    logic [6:0] exp_q[$];

    hazard_stall_ctrl #(.MEM_TIMEOUT(16), .WAIT_W(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .ResultSrcE(ResultSrcE),
        .RegWriteE(RegWriteE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
        .LoadStallCnt(LoadStallCnt), .FlushCnt(FlushCnt), .MemWaitCnt(MemWaitCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [1:0] rsrc, input logic [2:0] rw, input logic pcs,
                         input logic mreq, input logic mrdy);
        Rs1D = rs1; Rs2D = rs2; RdE = rd; ResultSrcE = rsrc; RegWriteE = rw;
        PCSrcE = pcs; MemReqM = mreq; MemReadyM = mrdy;
    endtask

    task automatic check_ctrl(input string tag);
        logic [6:0] exp;
        exp = exp_q.pop_front();
        chk(tag, {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'd0, exp});
    endtask

    // One clock: drive at negedge, compare combinational controls, then cross the edge.
    task automatic cyc(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [1:0] rsrc, input logic [2:0] rw,
                       input logic pcs, input logic mreq, input logic mrdy, input logic [6:0] exp);
        @(negedge clk);
        drive(rs1, rs2, rd, rsrc, rw, pcs, mreq, mrdy);
        exp_q.push_back(exp);
        #1 check_ctrl(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        cyc(tag, 5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, V_NONE);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(V_RST);
        #1 check_ctrl("rst_ctrl");
        @(posedge clk);
        #1;
        chk("rst_lscnt", 32'(LoadStallCnt), 32'd0);
        chk("rst_flcnt", 32'(FlushCnt), 32'd0);
        chk("rst_mwcnt", 32'(MemWaitCnt), 32'd0);
        chk("rst_memerr", 32'(MemErr), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        drive(5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0);
        do_reset();
        idle("idle0");

        // Load-use on Rs2D
        cyc("lw_use", 5'd1, 5'd5, 5'd5, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, V_LW);
        chk("lw_cnt1", 32'(LoadStallCnt), 32'd1);
        idle("lw_after");

        // Load to x0 never stalls
        cyc("lw_x0", 5'd0, 5'd3, 5'd0, 2'b01, 3'd1, 1'b0, 1'b0, 1'b0, V_NONE);
        cyc("lw_nowr", 5'd7, 5'd2, 5'd7, 2'b01, 3'd0, 1'b0, 1'b0, 1'b0, V_NONE);
        chk("lw_x0_cnt", 32'(LoadStallCnt), 32'd1);

        // Branch beats load-use
        cyc("br_lw", 5'd5, 5'd0, 5'd5, 2'b01, 3'd1, 1'b1, 1'b0, 1'b0, V_BR);
        chk("br_cnt1", 32'(FlushCnt), 32'd1);
        chk("br_lwcnt", 32'(LoadStallCnt), 32'd1);

        // Three wait cycles then ready
        for (int i = 0; i < 3; i++)
            cyc("mw_stall", 5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, V_MEM);
        cyc("mw_ready", 5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b1, V_NONE);
        chk("mw_cnt3", 32'(MemWaitCnt), 32'd3);
        idle("mw_after");

        // Branch and load-use deferred while waiting on memory
        cyc("dw_stall", 5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, V_MEM);
        cyc("dw_br", 5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b1, 1'b1, 1'b0, V_MEM);
        cyc("dw_lw", 5'd4, 5'd0, 5'd4, 2'b01, 3'd1, 1'b0, 1'b1, 1'b0, V_MEM);
        cyc("dw_rdy", 5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b1, 1'b1, 1'b1, V_NONE);
        cyc("dw_brrun", 5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b1, 1'b0, 1'b0, V_BR);
        chk("dw_flcnt", 32'(FlushCnt), 32'd2);
        chk("dw_lwcnt", 32'(LoadStallCnt), 32'd1);
        chk("dw_mwcnt", 32'(MemWaitCnt), 32'd6);

        // Watchdog: RUN stall cycle plus 16 counted waits before ERROR
        do_reset();
        for (int i = 0; i < 16; i++)
            cyc("to_stall", 5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, V_MEM);
        chk("to_noerr", 32'(MemErr), 32'd0);
        cyc("to_last", 5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, V_MEM);
        chk("to_err", 32'(MemErr), 32'd1);
        chk("to_mwsat", 32'(MemWaitCnt), 32'd15);
        cyc("err_hold", 5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b1, 1'b0, 1'b1, V_MEM);
        chk("err_sticky", 32'(MemErr), 32'd1);
        chk("err_noflcnt", 32'(FlushCnt), 32'd0);
        do_reset();
        idle("err_clear");

        // Reset in the middle of a wait restarts the watchdog from zero
        cyc("rm_stall", 5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, V_MEM);
        cyc("rm_stall", 5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, V_MEM);
        do_reset();
        cyc("rm_run", 5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b1, V_NONE);
        for (int i = 0; i < 16; i++)
            cyc("rm_wait", 5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, V_MEM);
        chk("rm_noerr", 32'(MemErr), 32'd0);
        cyc("rm_release", 5'd0, 5'd0, 5'd0, 2'b00, 3'd0, 1'b0, 1'b1, 1'b1, V_NONE);

        // Load-use counter saturation
        do_reset();
        for (int i = 0; i < 20; i++)
            cyc("sat_lw", 5'd9, 5'd1, 5'd9, 2'b01, 3'd4, 1'b0, 1'b0, 1'b0, V_LW);
        chk("sat_lwcnt", 32'(LoadStallCnt), 32'd15);
        idle("sat_after");
        chk("sat_hold", 32'(LoadStallCnt), 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
